reset_request_gen: RTL and testbench
====================================

// Module: reset_request_gen
// PURPOSE
//  Front end for the soft-reset stretcher: turns a raw, bouncy, active-low reset
//  button into reset requests. Short press -> key_reset request, held until the
//  stretcher reports the chip is in reset. Long press -> timed low pulse on host_reset_n.
//  Sits between board pin and reset stretcher, in clk50 domain.
// PARAMETERS
//  DEB_CYCLES   500000     stable cycles needed to accept a button level (10 ms @ 50 MHz)
//  LONG_CYCLES  100000000  debounced-press length that makes a long press (2 s)
//  HOST_PULSE   64         length of host_reset_n low pulse, cycles
//  ACK_TIMEOUT  1024       max cycles key_reset stays high without ack
// PORTS
//  clk50          in   1  system clock, 50 MHz
//  reset          in   1  synchronous, active-high
//  btn_n          in   1  raw button, asynchronous, active-low
//  chip_resetting in   1  stretcher busy flag (resetChip); serves as ack
//  key_reset      out  1  short-press request, active-high
//  host_reset_n   out  1  long-press reset pulse, active-low
//  busy           out  1  high in any state other than IDLE
// BEHAVIOUR
//  - Reset values: key_reset=0, host_reset_n=1, busy=0; state=IDLE; all counters 0.
//    Synchronizer flops reset to 1 (released).
//  - btn_n passes a 2-FF synchronizer, then the debouncer. The debounced level
//    btn_db changes only after the synced input differs from btn_db for DEB_CYCLES
//    consecutive cycles. Any disagreement-free cycle clears the counter.
//  - btn_db fall/rise give 1-cycle strobes press_s/release_s.
//    Latency from a clean pin edge to the strobe: 2 + DEB_CYCLES cycles.
//  - FSM:
//    IDLE:       press_s & !chip_resetting -> PRESSED, clear hold_cnt.
//                press_s while chip_resetting is ignored: stay IDLE, wait for release.
//    PRESSED:    hold_cnt increments and saturates at LONG_CYCLES.
//                release_s with hold_cnt<LONG_CYCLES -> SHORT_REQ.
//                hold_cnt reaches LONG_CYCLES-1 -> LONG_PULSE.
//    SHORT_REQ:  key_reset=1 (registered, rises the cycle after entry).
//                Exit to IDLE on chip_resetting=1 or when ack_cnt reaches ACK_TIMEOUT.
//                key_reset=0 the cycle after exit.
//    LONG_PULSE: host_reset_n=0 for exactly HOST_PULSE cycles, then WAIT_REL.
//    WAIT_REL:   outputs idle. btn_db high (released) -> IDLE.
//                If already released, leave next cycle.
//  - Simultaneous release_s and long threshold in the same cycle: long wins.
//  - Outputs are registered and glitch-free. key_reset and host_reset_n are never
//    active in the same cycle.
//  - A press during SHORT_REQ or LONG_PULSE is ignored. It is only seen again after
//    a release and a new press from IDLE.
//  - reset mid-operation aborts any state. Outputs are inactive the next cycle.
//  - Counter widths: $clog2(param+1). Counters saturate and never wrap.
// STRUCTURE
//  - Shared package: state encoding (IDLE=0, PRESSED=1, SHORT_REQ=2, LONG_PULSE=3,
//    WAIT_REL=4, 3 bits) and default timing constants shared with the stretcher.
//  - One sub-module: btn_debounce (synchronizer + debouncer + edge strobes),
//    parameter DEB_CYCLES.
//  - FSM, hold/ack/pulse counters and output registers stay in the top.
// TESTING (bench: DEB_CYCLES=4, LONG_CYCLES=20, HOST_PULSE=3, ACK_TIMEOUT=8)
//  1. btn_n low 10 cycles then high, chip_resetting rises 2 cycles after key_reset
//     -> key_reset high exactly 3 cycles, host_reset_n stays 1.
//  2. btn_n toggles every 2 cycles for 20 cycles, then steady high
//     -> no strobe, key_reset=0, busy=0 throughout.
//  3. btn_n low 40 cycles -> host_reset_n low exactly 3 cycles, starting 26 cycles
//     after the edge. key_reset stays 0. busy drops 1 cycle after release is debounced.
//  4. Short press, chip_resetting held 0 -> key_reset high 8 cycles, then 0, FSM in IDLE.
//  5. Press while chip_resetting=1 -> no output activity.
//     Release, then press again with ack low -> normal short request.
//  6. reset asserted during LONG_PULSE -> next cycle host_reset_n=1, busy=0, state IDLE.

Source files
------------

// File: rtl/reset_request_gen_pkg.sv
// -----------------------------------------------------------------------------
// reset_request_gen_pkg
//   Definitions shared by the reset-request front end and the reset stretcher:
//   the FSM state encoding and the default timing constants for a 50 MHz clk50.
// -----------------------------------------------------------------------------
package reset_request_gen_pkg;

  // FSM state encoding (3 bits, fixed values so the stretcher and debug
  // tooling can decode the state register directly).
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESSED    = 3'd1,
    SHORT_REQ  = 3'd2,
    LONG_PULSE = 3'd3,
    WAIT_REL   = 3'd4
  } rrg_state_e;

  // Default timing at 50 MHz.
  localparam int unsigned DEF_DEB_CYCLES  = 500_000;      // 10 ms debounce
  localparam int unsigned DEF_LONG_CYCLES = 100_000_000;  // 2 s long press
  localparam int unsigned DEF_HOST_PULSE  = 64;           // host_reset_n low time
  localparam int unsigned DEF_ACK_TIMEOUT = 1024;         // key_reset without ack

endpackage : reset_request_gen_pkg

// File: rtl/reset_request_gen_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Brings the raw active-low button into the clk50 domain, debounces it and
//   produces one-cycle press/release strobes.
//
// Ports
//   clk50      in   system clock
//   reset      in   synchronous, active-high
//   btn_n      in   raw button pin, asynchronous, active-low
//   btn_db     out  debounced level (1 = released)
//   press_s    out  1-cycle strobe on btn_db falling
//   release_s  out  1-cycle strobe on btn_db rising
//
// A clean pin edge shows up on the strobe 2 + DEB_CYCLES clock edges later:
// two synchronizer stages, then DEB_CYCLES consecutive disagreeing cycles.
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = reset_request_gen_pkg::DEF_DEB_CYCLES
) (
  input  logic clk50,
  input  logic reset,
  input  logic btn_n,
  output logic btn_db,
  output logic press_s,
  output logic release_s
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          btn_db_q, btn_db_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only advances while the synced input disagrees with btn_db;
  // the disagreement that completes the run flips btn_db and fires the strobe
  // in the same registered update, so the strobe is aligned with the new level.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d     = '0;
    btn_db_d  = btn_db_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != btn_db_q) begin
      if (cnt_q == CNT_LAST) begin
        btn_db_d  = sync2_q;
        press_d   = ~sync2_q;
        release_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      // NOTE: the synchronizer and debounced level reset to the released
      // level (1) so leaving reset never looks like a button press.
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      btn_db_q  <= 1'b1;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would collapse the two synchronizer stages into one.
      sync1_q   <= btn_n;
      sync2_q   <= sync1_q;
      btn_db_q  <= btn_db_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_db    = btn_db_q;
  assign press_s   = press_q;
  assign release_s = release_q;

endmodule : btn_debounce

// File: rtl/reset_request_gen.sv
// -----------------------------------------------------------------------------
// reset_request_gen
//   Front end for the soft-reset stretcher. Turns the bouncy reset button into
//   a short-press request (key_reset, held until the stretcher acknowledges
//   via chip_resetting or a timeout) or, for a long press, a timed low pulse
//   on host_reset_n.
//
// Ports
//   clk50           in   system clock, 50 MHz
//   reset           in   synchronous, active-high
//   btn_n           in   raw button, asynchronous, active-low
//   chip_resetting  in   stretcher busy flag, used as acknowledge
//   key_reset       out  short-press request, active-high
//   host_reset_n    out  long-press reset pulse, active-low
//   busy            out  high whenever the FSM is not in IDLE
//
// All outputs are flops decoded from the next state, so each output changes
// on the same edge as the state it belongs to and never glitches.
// -----------------------------------------------------------------------------
module reset_request_gen
  import reset_request_gen_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int unsigned HOST_PULSE  = DEF_HOST_PULSE,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic clk50,
  input  logic reset,
  input  logic btn_n,
  input  logic chip_resetting,
  output logic key_reset,
  output logic host_reset_n,
  output logic busy
);

  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned PW = $clog2(HOST_PULSE + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [AW-1:0] ACK_MAX   = AW'(ACK_TIMEOUT);
  localparam logic [PW-1:0] PULSE_MAX = PW'(HOST_PULSE);

  logic btn_db, press_s, release_s;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk50     (clk50),
    .reset     (reset),
    .btn_n     (btn_n),
    .btn_db    (btn_db),
    .press_s   (press_s),
    .release_s (release_s)
  );

  rrg_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [AW-1:0] ack_q, ack_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic          key_reset_q, key_reset_d;
  logic          host_reset_n_q, host_reset_n_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ack_d   = ack_q;
    pulse_d = pulse_q;

    unique case (state_q)
      IDLE: begin
        hold_d  = '0;
        ack_d   = '0;
        pulse_d = '0;
        // A press while the chip is already resetting is dropped; the next
        // press_s can only come after a debounced release.
        if (press_s && !chip_resetting) begin
          state_d = PRESSED;
        end
      end

      PRESSED: begin
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
        ack_d  = '0;
        // Long threshold is tested first so it wins over a coincident release.
        if (hold_d == HOLD_LAST) begin
          state_d = LONG_PULSE;
          pulse_d = '0;
        end else if (release_s && (hold_q < HOLD_MAX)) begin
          state_d = SHORT_REQ;
        end
      end

      SHORT_REQ: begin
        ack_d = (ack_q == ACK_MAX) ? ack_q : ack_q + AW'(1);
        if (chip_resetting || (ack_d == ACK_MAX)) begin
          state_d = IDLE;
        end
      end

      LONG_PULSE: begin
        pulse_d = (pulse_q == PULSE_MAX) ? pulse_q : pulse_q + PW'(1);
        if (pulse_d == PULSE_MAX) begin
          state_d = WAIT_REL;
        end
      end

      WAIT_REL: begin
        if (btn_db) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    key_reset_d    = (state_d == SHORT_REQ);
    host_reset_n_d = (state_d != LONG_PULSE);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q        <= IDLE;
      hold_q         <= '0;
      ack_q          <= '0;
      pulse_q        <= '0;
      key_reset_q    <= 1'b0;
      host_reset_n_q <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      ack_q          <= ack_d;
      pulse_q        <= pulse_d;
      key_reset_q    <= key_reset_d;
      host_reset_n_q <= host_reset_n_d;
      busy_q         <= busy_d;
    end
  end

  assign key_reset    = key_reset_q;
  assign host_reset_n = host_reset_n_q;
  assign busy         = busy_q;

endmodule : reset_request_gen

// File: tb/tb_reset_request_gen.sv
// -----------------------------------------------------------------------------
// tb_reset_request_gen
//   Directed bench with a pulse scoreboard. Stimulus pushes the expected
//   key_reset / host_reset_n pulses (start edge and length); a monitor on the
//   falling clock edge measures every pulse the DUT produces and pops/compares.
//   Edge numbering: the stimulus changes pins #1 after edge t0, the monitor
//   reports the number of the edge after which an output first changed.
// -----------------------------------------------------------------------------
module tb_reset_request_gen;
  import reset_request_gen_pkg::*;

  localparam int DEB   = 4;
  localparam int LONG  = 20;
  localparam int PULSE = 3;
  localparam int ACK   = 8;

  // Hand-derived latencies for these parameters (pin edge after edge t0):
  //   press_s after edge t0+6, PRESSED at t0+7, hold hits 19 at t0+26.
  //   Release after edge t0+10 -> release_s after t0+16 -> SHORT_REQ at t0+17.
  localparam int SHORT_START = 17;
  localparam int LONG_START  = 26;

  logic clk50          = 1'b0;
  logic reset          = 1'b1;
  logic btn_n          = 1'b1;
  logic chip_resetting = 1'b0;
  logic key_reset, host_reset_n, busy;

  reset_request_gen #(
    .DEB_CYCLES  (DEB),
    .LONG_CYCLES (LONG),
    .HOST_PULSE  (PULSE),
    .ACK_TIMEOUT (ACK)
  ) dut (
    .clk50          (clk50),
    .reset          (reset),
    .btn_n          (btn_n),
    .chip_resetting (chip_resetting),
    .key_reset      (key_reset),
    .host_reset_n   (host_reset_n),
    .busy           (busy)
  );

  always #10 clk50 = ~clk50;

  int cyc = 0;
  always @(posedge clk50) cyc <= cyc + 1;

  typedef struct {
    bit is_host;
    int start;
    int len;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic expect_ev(input bit is_host, input int start, input int len);
    ev_t e;
    e.is_host = is_host;
    e.start   = start;
    e.len     = len;
    exp_q.push_back(e);
  endtask

  task automatic compare_ev(input bit is_host, input int start, input int len);
    ev_t e;
    check(is_host ? "host_pulse_expected" : "key_pulse_expected",
          int'(exp_q.size() > 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("pulse_kind_is_host", int'(is_host), int'(e.is_host));
    check(is_host ? "host_pulse_start" : "key_pulse_start", start, e.start);
    check(is_host ? "host_pulse_len" : "key_pulse_len", len, e.len);
  endtask

  // Monitor: measures output pulses on the falling edge.
  logic key_prev   = 1'b0;
  logic host_prev  = 1'b1;
  int   key_start  = 0;
  int   host_start = 0;

  always @(negedge clk50) begin
    if (mon_en) begin
      check("outputs_exclusive", int'(key_reset && !host_reset_n), 0);
      if (key_reset && !key_prev) key_start <= cyc;
      if (!key_reset && key_prev) compare_ev(1'b0, key_start, cyc - key_start);
      if (!host_reset_n && host_prev) host_start <= cyc;
      if (host_reset_n && !host_prev) compare_ev(1'b1, host_start, cyc - host_start);
    end
    key_prev  <= key_reset;
    host_prev <= host_reset_n;
  end

  int t0;

  initial begin
    // Reset state
    step(3);
    check("rst_key_reset", int'(key_reset), 0);
    check("rst_host_reset_n", int'(host_reset_n), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(dut.state_q), int'(IDLE));
    reset  = 1'b0;
    mon_en = 1'b1;
    step(5);

    // 1: short press, ack 2 cycles after key_reset rises -> key high 3 cycles
    t0 = cyc;
    btn_n = 1'b0;
    expect_ev(1'b0, t0 + SHORT_START, 3);
    step(10);
    btn_n = 1'b1;
    step(9);                                  // now at edge t0+19
    check("t1_key_high_before_ack", int'(key_reset), 1);
    chip_resetting = 1'b1;
    step(3);
    chip_resetting = 1'b0;
    step(10);
    check("t1_busy_end", int'(busy), 0);

    // 2: bounce shorter than DEB_CYCLES -> nothing happens
    for (int i = 0; i < 10; i++) begin
      btn_n = ~btn_n;
      step(2);
      check("t2_busy", int'(busy), 0);
      check("t2_key_reset", int'(key_reset), 0);
    end
    step(10);
    check("t2_busy_end", int'(busy), 0);

    // 3: long press -> host_reset_n low 3 cycles from edge t0+26
    t0 = cyc;
    btn_n = 1'b0;
    expect_ev(1'b1, t0 + LONG_START, PULSE);
    step(40);
    btn_n = 1'b1;                             // release after edge t0+40
    step(6);                                  // btn_db rises at edge t0+46
    check("t3_busy_at_release_db", int'(busy), 1);
    check("t3_state_wait_rel", int'(dut.state_q), int'(WAIT_REL));
    step(1);
    check("t3_busy_drop", int'(busy), 0);
    step(5);

    // 4: short press, no ack -> key_reset high ACK_TIMEOUT cycles
    t0 = cyc;
    btn_n = 1'b0;
    expect_ev(1'b0, t0 + SHORT_START, ACK);
    step(10);
    btn_n = 1'b1;
    step(7);                                  // edge t0+17
    check("t4_busy_in_short", int'(busy), 1);
    step(8);                                  // edge t0+25
    check("t4_key_reset_off", int'(key_reset), 0);
    check("t4_state_idle", int'(dut.state_q), int'(IDLE));
    check("t4_busy_off", int'(busy), 0);
    step(5);

    // 5: press while chip is resetting is ignored, next press works
    chip_resetting = 1'b1;
    btn_n = 1'b0;
    step(10);
    check("t5_ignored_busy", int'(busy), 0);
    check("t5_ignored_state", int'(dut.state_q), int'(IDLE));
    btn_n = 1'b1;
    step(10);
    check("t5_after_release_busy", int'(busy), 0);
    chip_resetting = 1'b0;
    step(2);
    t0 = cyc;
    btn_n = 1'b0;
    expect_ev(1'b0, t0 + SHORT_START, ACK);
    step(10);
    btn_n = 1'b1;
    step(20);
    check("t5_second_busy_end", int'(busy), 0);

    // 6: reset during LONG_PULSE truncates the pulse to 2 cycles
    t0 = cyc;
    btn_n = 1'b0;
    expect_ev(1'b1, t0 + LONG_START, 2);
    step(27);                                 // edge t0+27, pulse in progress
    check("t6_host_low", int'(host_reset_n), 0);
    check("t6_busy_high", int'(busy), 1);
    reset = 1'b1;
    btn_n = 1'b1;
    step(1);
    check("t6_host_released", int'(host_reset_n), 1);
    check("t6_busy_cleared", int'(busy), 0);
    check("t6_key_reset", int'(key_reset), 0);
    check("t6_state_idle", int'(dut.state_q), int'(IDLE));
    step(1);
    reset = 1'b0;
    step(20);
    check("t6_quiet_after_reset", int'(busy), 0);

    step(5);
    check("pending_expected_pulses", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reset_request_gen
